// File: rtl/min2_finder_pkg.sv
// Shared definitions for the minimum search and minimum storage stages:
// magnitude width, search initial value and both stages' FSM encodings.
package min2_finder_pkg;

   localparam int               MIN_W    = 6;
   localparam logic [MIN_W-1:0] MIN_INIT = 6'h3F;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   // Downstream storage stage captures mini1/mini2 while in SORT/SORT_DECODE.
   typedef enum logic [1:0] {STORE_WAIT, SORT, SORT_DECODE} store_state_t;

endpackage

// File: rtl/min2_finder_insert.sv
// Combinational insertion of one sample into the running (mini1, mini2) pair.
// Strict compares keep the first occurrence of a tied minimum in place.
module min2_insert
   import min2_finder_pkg::*;
#(
   parameter int W = MIN_W
) (
   input  logic [W-1:0] din,
   input  logic [W-1:0] mini1,
   input  logic [W-1:0] mini2,
   output logic [W-1:0] mini1_nxt,
   output logic [W-1:0] mini2_nxt,
   output logic         new_min
);

   // NOTE: every output gets a default first so no path can infer a latch.
   always_comb begin
      mini1_nxt = mini1;
      mini2_nxt = mini2;
      new_min   = 1'b0;
      if (din < mini1) begin
         mini2_nxt = mini1;
         mini1_nxt = din;
         new_min   = 1'b1;
      end else if (din < mini2) begin
         mini2_nxt = din;
      end
   end

endmodule

// File: rtl/min2_finder.sv
// Streaming two-minimum search over an N-sample frame; presents the smallest,
// second-smallest and index of the smallest with a one-cycle done pulse.
module min2_finder
   import min2_finder_pkg::*;
#(
   parameter int W  = MIN_W,
   parameter int N  = 8,   // at least 2
   parameter int AW = 3    // 2**AW >= N
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          din_valid,
   input  logic [W-1:0]  din,
   output logic          din_ready,
   output logic [W-1:0]  mini1,
   output logic [W-1:0]  mini2,
   output logic [AW-1:0] min_idx,
   output logic          busy,
   output logic          done
);

   localparam logic [AW-1:0] LAST = AW'(N - 1);

   state_t        state;
   logic [AW-1:0] cnt;
   logic [W-1:0]  mini1_nxt;
   logic [W-1:0]  mini2_nxt;
   logic          new_min;

   min2_insert #(.W(W)) u_insert (
      .din       (din),
      .mini1     (mini1),
      .mini2     (mini2),
      .mini1_nxt (mini1_nxt),
      .mini2_nxt (mini2_nxt),
      .new_min   (new_min)
   );

   // NOTE: all state updates use non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         mini1     <= '0;
         mini2     <= '0;
         min_idx   <= '0;
         din_ready <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state     <= SCAN;
                  cnt       <= '0;
                  mini1     <= {W{1'b1}};
                  mini2     <= {W{1'b1}};
                  min_idx   <= '0;
                  din_ready <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            SCAN: begin
               if (din_valid && din_ready) begin
                  mini1 <= mini1_nxt;
                  mini2 <= mini2_nxt;
                  if (new_min) min_idx <= cnt;
                  cnt <= cnt + 1'b1;
                  // Last sample accepted: ready drops with the state change.
                  if (cnt == LAST) begin
                     state     <= DONE;
                     din_ready <= 1'b0;
                     done      <= 1'b1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               din_ready <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_min2_finder.sv
// Directed bench for min2_finder: frame table plus idle and mid-frame reset sequences.
module tb_min2_finder;

   localparam int W  = 6;
   localparam int N  = 8;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          din_valid;
   logic [W-1:0]  din;
   logic          din_ready;
   logic [W-1:0]  mini1;
   logic [W-1:0]  mini2;
   logic [AW-1:0] min_idx;
   logic          busy;
   logic          done;

   int tests = 0;
   int fails = 0;

   typedef struct {
      string         name;
      logic [W-1:0]  s [N];
      bit            stall;
      logic [W-1:0]  e1;
      logic [W-1:0]  e2;
      logic [AW-1:0] ei;
   } frame_t;

   frame_t vec [6];

   min2_finder #(.W(W), .N(N), .AW(AW)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .din_valid (din_valid),
      .din       (din),
      .din_ready (din_ready),
      .mini1     (mini1),
      .mini2     (mini2),
      .min_idx   (min_idx),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input int e1, input int e2, input int ei);
      check({tag, " mini1"},   int'(mini1),   e1);
      check({tag, " mini2"},   int'(mini2),   e2);
      check({tag, " min_idx"}, int'(min_idx), ei);
   endtask

   // Called at a negedge in IDLE; returns at the negedge of the following IDLE cycle,
   // so consecutive calls issue back-to-back frames.
   task automatic run_frame(input frame_t f);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({f.name, " ready after start"}, int'(din_ready), 1);
      check({f.name, " busy after start"},  int'(busy), 1);
      for (int i = 0; i < N; i++) begin
         din_valid = 1'b1;
         din       = f.s[i];
         @(negedge clk);
         if (i < N - 1) begin
            check($sformatf("%s done low after accept %0d", f.name, i), int'(done), 0);
            if (f.stall && (i % 2 == 1)) begin
               din_valid = 1'b0;
               din       = '0;
               for (int k = 0; k < 3; k++) begin
                  start = (k == 1);
                  @(negedge clk);
                  check($sformatf("%s stall ready %0d", f.name, i), int'(din_ready), 1);
                  check($sformatf("%s stall done %0d", f.name, i), int'(done), 0);
               end
               start = 1'b0;
            end
         end
      end
      din_valid = 1'b0;
      din       = '0;
      check({f.name, " done pulse"}, int'(done), 1);
      check({f.name, " ready in done"}, int'(din_ready), 0);
      check_outs({f.name, " result"}, f.e1, f.e2, f.ei);
      @(negedge clk);
      check({f.name, " done single"}, int'(done), 0);
      check({f.name, " busy idle"}, int'(busy), 0);
      check_outs({f.name, " hold"}, f.e1, f.e2, f.ei);
   endtask

   initial begin
      vec[0] = '{name:"basic", s:'{12, 5, 40, 5, 63, 7, 0, 33}, stall:0, e1:0,  e2:5,  ei:6};
      vec[1] = '{name:"ties",  s:'{9, 3, 3, 20, 3, 50, 60, 10}, stall:0, e1:3,  e2:3,  ei:1};
      vec[2] = '{name:"stall", s:'{12, 5, 40, 5, 63, 7, 0, 33}, stall:1, e1:0,  e2:5,  ei:6};
      vec[3] = '{name:"allmax", s:'{63, 63, 63, 63, 63, 63, 63, 63}, stall:0, e1:63, e2:63, ei:0};
      vec[4] = '{name:"desc",  s:'{7, 6, 5, 4, 3, 2, 1, 0},     stall:0, e1:0,  e2:1,  ei:7};
      vec[5] = '{name:"asc",   s:'{0, 1, 2, 3, 4, 5, 6, 7},     stall:0, e1:0,  e2:1,  ei:0};

      reset     = 1'b0;
      start     = 1'b0;
      din_valid = 1'b0;
      din       = '0;
      repeat (2) @(negedge clk);
      check_outs("reset", 0, 0, 0);
      check("reset ready", int'(din_ready), 0);
      check("reset busy",  int'(busy), 0);
      check("reset done",  int'(done), 0);
      reset = 1'b1;

      // Valid pulses while idle must be ignored.
      for (int i = 0; i < 3; i++) begin
         din_valid = 1'b1;
         din       = W'(i + 1);
         @(negedge clk);
         din_valid = 1'b0;
         @(negedge clk);
      end
      check_outs("idle valid", 0, 0, 0);
      check("idle ready", int'(din_ready), 0);
      check("idle busy",  int'(busy), 0);

      for (int v = 0; v < 6; v++) run_frame(vec[v]);

      // Reset after the 4th accept discards the frame.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         din_valid = 1'b1;
         din       = W'(10 - i);
         @(negedge clk);
      end
      reset = 1'b0;
      @(negedge clk);
      check_outs("midreset", 0, 0, 0);
      check("midreset ready", int'(din_ready), 0);
      check("midreset busy",  int'(busy), 0);
      check("midreset done",  int'(done), 0);
      reset     = 1'b1;
      din_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("midreset no done", int'(done), 0);
      end
      run_frame(vec[0]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/min2_finder.md
# min2_finder

Streaming two-minimum search stage that sits directly upstream of the minimum storage register. It accepts a frame of N unsigned 6-bit magnitudes, one per accepted handshake, and tracks the smallest value, the second-smallest value and the index of the smallest. At end of frame it presents `mini1`/`mini2` with a one-cycle `done` pulse for the storage stage to capture during `SORT`/`SORT_DECODE`.

## Interface
- `W`, default 6: magnitude width.
- `N`, default 8: samples per frame. Must be at least 2.
- `AW`, default 3: index width. Must satisfy 2^AW ≥ N.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low reset, sampled on `clk`.
- `start`  in  1  begins a frame; honoured only in IDLE.
- `din_valid`  in  1  `din` is valid this cycle.
- `din`  in  W  unsigned sample.
- `din_ready`  out  1  high only in SCAN.
- `mini1`  out  W  smallest value in the frame.
- `mini2`  out  W  second-smallest value in the frame; a duplicate of `mini1` is allowed.
- `min_idx`  out  AW  arrival position (0..N-1) of `mini1`.
- `busy`  out  1  high in SCAN and DONE.
- `done`  out  1  one-cycle pulse; results are valid in that cycle.

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - `start`=1 → SCAN.
  - On that edge: `mini1` and `mini2` load 2^W−1 (63), `min_idx` loads 0, the sample counter `cnt` loads 0.
- SCAN:
  - An accept is `din_valid && din_ready`.
  - On each accept, if `din < mini1`: `mini2` ← `mini1`, `mini1` ← `din`, `min_idx` ← `cnt`.
  - Else if `din < mini2`: `mini2` ← `din`.
  - Else: no change.
  - `cnt` increments on each accept.
  - Accepting the sample while `cnt == N-1` → DONE.
- DONE: `done`=1 for exactly one cycle, then unconditional → IDLE.
- Ties:
  - A value equal to `mini1` does not displace `mini1` or `min_idx`. The first occurrence wins.
  - That tied value becomes `mini2` if it is less than the current `mini2`.
- `din_valid` low in SCAN stalls the frame indefinitely with no state change.
- `start` in SCAN or DONE is ignored; it does not restart the frame.
- `mini1`, `mini2` and `min_idx` hold their values from DONE through IDLE until the next `start`.
- A frame of all 63s gives `mini1`=`mini2`=63 and `min_idx`=0.
- Reset mid-frame discards the frame. The state returns to IDLE and all outputs take their reset values on the next edge.
- Comparisons are unsigned at W bits. No arithmetic is performed, so no widening is needed.

## Timing
- Reset values: `mini1`=0, `mini2`=0, `min_idx`=0, `din_ready`=0, `busy`=0, `done`=0, FSM=IDLE, `cnt`=0.
- `din_ready` and `busy` rise the cycle after `start` is sampled.
- Latency: `done` is asserted the cycle after the N-th accept. With no stalls this is N+1 cycles after the `start` edge.
- Outputs are registered. `mini1`, `mini2` and `min_idx` are stable and final in the `done` cycle.
- Back-to-back frames:
  - `start` may be asserted in the IDLE cycle immediately following DONE.
  - The minimum frame period is N+2 cycles.
- `din_ready` is a registered function of state only. It has no combinational path from `din_valid`.

## Structure
- Shared defines/package:
  - FSM encodings (`IDLE`, `SCAN`, `DONE`), in the same include that carries `SORT`/`SORT_DECODE`.
  - `MIN_W`=6.
  - `MIN_INIT`=6'h3F.
- One natural sub-module, `min2_insert`. It is combinational: inputs `din`, `mini1`, `mini2`; outputs next `mini1`, next `mini2` and the flag `new_min`.
- The FSM, counter and output registers live in `min2_finder`.

## Test plan
- Reset and idle: drive `reset`=0 for 2 cycles, then release.
  - Required: all outputs 0, `din_ready`=0.
  - Required: `din_valid` pulses while idle change nothing.
- Basic frame: `start`, then 12, 5, 40, 5, 63, 7, 0, 33 with no stalls.
  - Required: `done` in the cycle after the 8th accept.
  - Required: `mini1`=0, `mini2`=5, `min_idx`=6.
- Ties: samples 9, 3, 3, 20, 3, 50, 60, 10.
  - Required: `mini1`=3, `mini2`=3, `min_idx`=1.
- Stalls: the basic frame with `din_valid` low for 3 cycles after every other sample.
  - Required: the same results as the basic frame.
  - Required: `done` only after the 8th accept; `start` pulses during SCAN are ignored.
- All-max frame then back-to-back: first frame all 63s, then `start` asserted in the IDLE cycle right after DONE with descending 7..0.
  - Required: first frame gives `mini1`=`mini2`=63, `min_idx`=0.
  - Required: second frame gives `mini1`=0, `mini2`=1, `min_idx`=7.
- Reset mid-frame: `reset`=0 after the 4th accept.
  - Required: next edge gives IDLE, outputs 0, `done` never pulses.
  - Required: a fresh `start` then completes a correct frame.
